fir_seq_ctrl: RTL and testbench
===============================

FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

Interface
REQ-001 Clk  input  1  sole clock; all state updates on rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset.
REQ-003 PushIn  input  1  sample push from upstream; honoured only when StopIn=0.
REQ-004 StopIn  output  1  back-pressure to upstream; 1 = sample not accepted this cycle.
REQ-005 PushCoef  input  1  coefficient write strobe.
REQ-006 CoefAddr  input  5  coefficient address; legal range 1..15.
REQ-007 CoefWe  output  1  write enable to the coefficient bank.
REQ-008 CoefWAddr  output  4  registered copy of CoefAddr[3:0] accompanying CoefWe.
REQ-009 SampWe  output  1  delay-line write enable; pulses for one cycle per accepted sample.
REQ-010 WrPtr  output  5  delay-line write address, mod 32.
REQ-011 TapAddr  output  4  coefficient read address, 1..15, during MAC.
REQ-012 RdPtrA, RdPtrB  output  5 each  delay-line read addresses for the symmetric sample pair.
REQ-013 RdValidA, RdValidB  output  1 each  1 = the addressed sample exists (age < FillCnt); 0 = the datapath substitutes zero.
REQ-014 MacEn, MacClr, MacPair  output  1 each  accumulate enable, clear-on-first-tap, add-B-operand.
REQ-015 PushOut  output  1  one-cycle pulse when the datapath FI/FQ result is valid.
REQ-016 CoefErr  output  1  sticky illegal-coefficient-write flag.

Function
REQ-017 Parameters: NTAPS=29, NCOEF=15, MAC_LAT=2. Coefficients 1..14 are mirrored; coefficient 15 is the centre tap.
REQ-018 States are LOAD, IDLE, MAC and DRAIN; Reset forces LOAD.
REQ-019 LOAD: StopIn=1; each PushCoef with a legal address sets bit CoefAddr of a 15-bit valid mask. The block moves to IDLE on the first cycle where the mask is all-ones and PushCoef=0.
REQ-020 IDLE: StopIn=0. PushIn=1 causes SampWe=1 at the current WrPtr. On the next edge: N := WrPtr, WrPtr increments mod 32, FillCnt increments saturating at 29, and state goes to MAC with tap=1.
REQ-021 MAC lasts exactly 15 cycles with StopIn=1 and MacEn=1. TapAddr=tap. MacClr=1 only when tap=1.
REQ-022 MAC taps 1..14: RdPtrA=N-(tap-1), RdPtrB=N-(29-tap), both mod 32, with MacPair=1.
REQ-023 MAC tap 15: RdPtrA=RdPtrB=N-14, MacPair=0.
REQ-024 RdValidA=(ageA<FillCnt) and RdValidB=(ageB<FillCnt), where age is the distance back from N.
REQ-025 After tap 15 the block enters DRAIN for MAC_LAT cycles with StopIn=1 and MacEn=0. On the last DRAIN cycle PushOut=1 and the next state is IDLE.
REQ-026 Latency: PushOut is asserted exactly 17 cycles after the accepting PushIn cycle. Throughput is one sample per 18 cycles.
REQ-027 CoefWe/CoefWAddr are registered one cycle after a legal PushCoef accepted in LOAD or IDLE. An IDLE write updates the bank and the state remains IDLE.
REQ-028 PushCoef in MAC or DRAIN, or with CoefAddr in {0, 16..31}, is dropped (CoefWe=0) and sets CoefErr. CoefErr clears only on Reset.
REQ-029 PushIn while StopIn=1 is ignored: no SampWe and no pointer change.
REQ-030 Simultaneous PushIn and PushCoef in IDLE: both are accepted, and the coefficient write lands before tap 1 reads it.
REQ-031 WrPtr wraps 31->0 without a gap. All pointer arithmetic is 5-bit modular.

Reset
REQ-032 Synchronous reset values: state=LOAD, StopIn=1, all strobes 0, all pointers/addresses 0, FillCnt=0, valid mask=0, CoefErr=0.
REQ-033 Reset asserted mid-MAC or mid-DRAIN aborts the block with no PushOut and requires the coefficients to be reloaded.

Structure
REQ-034 Package fir_ctrl_pkg holds the state enum, NTAPS, NCOEF, MAC_LAT and PTR_W=5.
REQ-035 Pointer/valid generation is sub-module fir_tap_addr_gen (inputs N, tap, FillCnt; outputs RdPtrA/B, RdValidA/B, MacPair).

Verification
REQ-036 Reset, write addrs 1..15, drop PushCoef -> IDLE the next cycle with StopIn 1->0, CoefErr=0.
REQ-037 First sample at WrPtr=0 -> tap1: RdPtrA=0, RdPtrB=4, RdValidA=1, RdValidB=0; tap15: ptr 18, MacPair=0; PushOut 17 cycles later.
REQ-038 35 samples -> WrPtr wraps 31->0. After sample 29 all RdValid=1. For N=2, tap1: RdPtrB=6.
REQ-039 PushCoef addr 0, then addr 20, then addr 5 during MAC -> CoefWe never asserted, CoefErr=1 until Reset.
REQ-040 PushIn held high continuously -> exactly one SampWe per 18 cycles, with no SampWe while StopIn=1.
REQ-041 Reset at tap 7 -> next cycle LOAD, StopIn=1, no PushOut, FillCnt=0.

Source files
------------

// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the symmetric 29-tap FIR sequencer.
package fir_ctrl_pkg;
   localparam int NTAPS   = 29;
   localparam int NCOEF   = 15;
   localparam int MAC_LAT = 2;
   localparam int PTR_W   = 5;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      IDLE  = 2'd1,
      MAC   = 2'd2,
      DRAIN = 2'd3
   } state_t;
endpackage

// File: rtl/fir_tap_addr_gen.sv
// Delay-line read addresses and validity for one tap of the folded FIR.
module fir_tap_addr_gen
   import fir_ctrl_pkg::*;
(
   input  logic [PTR_W-1:0] N,
   input  logic [3:0]       Tap,
   input  logic [PTR_W-1:0] FillCnt,
   output logic [PTR_W-1:0] RdPtrA,
   output logic [PTR_W-1:0] RdPtrB,
   output logic             RdValidA,
   output logic             RdValidB,
   output logic             MacPair
);

   logic [PTR_W-1:0] age_a;
   logic [PTR_W-1:0] age_b;

   // Ages are counted back from the newest sample N; the centre tap reads one sample once.
   always_comb begin
      if (Tap == 4'(NCOEF)) begin
         age_a   = PTR_W'((NTAPS - 1) / 2);
         age_b   = PTR_W'((NTAPS - 1) / 2);
         MacPair = 1'b0;
      end else begin
         age_a   = PTR_W'(Tap) - PTR_W'(1);
         age_b   = PTR_W'(NTAPS) - PTR_W'(Tap);
         MacPair = 1'b1;
      end
   end

   assign RdPtrA   = N - age_a;
   assign RdPtrB   = N - age_b;
   assign RdValidA = (age_a < FillCnt);
   assign RdValidB = (age_b < FillCnt);

endmodule

// File: rtl/fir_seq_ctrl.sv
// Sequencer for a folded symmetric FIR: coefficient load, sample accept, 15-tap MAC, drain.
module fir_seq_ctrl
   import fir_ctrl_pkg::*;
(
   input  logic             Clk,
   input  logic             Reset,
   input  logic             PushIn,
   output logic             StopIn,
   input  logic             PushCoef,
   input  logic [4:0]       CoefAddr,
   output logic             CoefWe,
   output logic [3:0]       CoefWAddr,
   output logic             SampWe,
   output logic [PTR_W-1:0] WrPtr,
   output logic [3:0]       TapAddr,
   output logic [PTR_W-1:0] RdPtrA,
   output logic [PTR_W-1:0] RdPtrB,
   output logic             RdValidA,
   output logic             RdValidB,
   output logic             MacEn,
   output logic             MacClr,
   output logic             MacPair,
   output logic             PushOut,
   output logic             CoefErr,
   output state_t           StateDbg,
   output logic [PTR_W-1:0] FillCnt
);

   state_t           state;
   logic             stop_in;
   logic [3:0]       tap;
   logic [PTR_W-1:0] n;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] fill_cnt;
   logic [1:0]       drain_cnt;
   logic [NCOEF-1:0] mask;
   logic             coef_err;
   logic             coef_we;
   logic [3:0]       coef_waddr;
   logic             coef_legal;
   logic [NCOEF-1:0] coef_bit;
   logic [PTR_W-1:0] gen_ptr_a, gen_ptr_b;
   logic             gen_valid_a, gen_valid_b, gen_pair;
   logic             in_mac;

   // Upstream handshake: a sample transfers in any cycle where PushIn=1 and StopIn=0;
   // PushIn while StopIn=1 has no effect and the sample must be re-presented.
   assign coef_legal = PushCoef && (CoefAddr != 5'd0) && !CoefAddr[4] &&
                       (state == LOAD || state == IDLE);
   assign coef_bit   = NCOEF'(1) << (CoefAddr[3:0] - 4'd1);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= LOAD;
         stop_in    <= 1'b1;
         tap        <= '0;
         n          <= '0;
         wr_ptr     <= '0;
         fill_cnt   <= '0;
         drain_cnt  <= '0;
         mask       <= '0;
         coef_err   <= 1'b0;
         coef_we    <= 1'b0;
         coef_waddr <= '0;
      end else begin
         coef_we <= coef_legal;
         if (coef_legal)
            coef_waddr <= CoefAddr[3:0];
         if (PushCoef && !coef_legal)
            coef_err <= 1'b1;

         case (state)
            LOAD: begin
               if (coef_legal)
                  mask <= mask | coef_bit;
               if (mask == '1 && !PushCoef) begin
                  state   <= IDLE;
                  stop_in <= 1'b0;
               end
            end
            IDLE: begin
               if (PushIn) begin
                  n       <= wr_ptr;
                  wr_ptr  <= wr_ptr + PTR_W'(1);
                  if (fill_cnt != PTR_W'(NTAPS))
                     fill_cnt <= fill_cnt + PTR_W'(1);
                  tap     <= 4'd1;
                  state   <= MAC;
                  stop_in <= 1'b1;
               end
            end
            MAC: begin
               if (tap == 4'(NCOEF)) begin
                  state     <= DRAIN;
                  drain_cnt <= '0;
               end else begin
                  tap <= tap + 4'd1;
               end
            end
            DRAIN: begin
               if (drain_cnt == 2'(MAC_LAT - 1)) begin
                  state   <= IDLE;
                  stop_in <= 1'b0;
               end else begin
                  drain_cnt <= drain_cnt + 2'd1;
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

   fir_tap_addr_gen u_addr_gen (
      .N        (n),
      .Tap      (tap),
      .FillCnt  (fill_cnt),
      .RdPtrA   (gen_ptr_a),
      .RdPtrB   (gen_ptr_b),
      .RdValidA (gen_valid_a),
      .RdValidB (gen_valid_b),
      .MacPair  (gen_pair)
   );

   assign in_mac    = (state == MAC);
   assign StopIn    = stop_in;
   assign SampWe    = PushIn && !stop_in;
   assign WrPtr     = wr_ptr;
   assign FillCnt   = fill_cnt;
   assign CoefWe    = coef_we;
   assign CoefWAddr = coef_waddr;
   assign CoefErr   = coef_err;
   assign StateDbg  = state;
   assign MacEn     = in_mac;
   assign MacClr    = in_mac && (tap == 4'd1);
   assign TapAddr   = in_mac ? tap : 4'd0;
   assign RdPtrA    = in_mac ? gen_ptr_a : '0;
   assign RdPtrB    = in_mac ? gen_ptr_b : '0;
   assign RdValidA  = in_mac && gen_valid_a;
   assign RdValidB  = in_mac && gen_valid_b;
   assign MacPair   = in_mac && gen_pair;
   assign PushOut   = (state == DRAIN) && (drain_cnt == 2'(MAC_LAT - 1));

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Randomised scoreboard bench for fir_seq_ctrl against a cycle-schedule reference model.
module tb_fir_seq_ctrl;
   import fir_ctrl_pkg::*;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       PushIn = 1'b0;
   logic       PushCoef = 1'b0;
   logic [4:0] CoefAddr = 5'd0;
   logic       StopIn, CoefWe, SampWe, RdValidA, RdValidB;
   logic       MacEn, MacClr, MacPair, PushOut, CoefErr;
   logic [3:0] CoefWAddr, TapAddr;
   logic [4:0] WrPtr, RdPtrA, RdPtrB, FillCnt;
   state_t     StateDbg;

   fir_seq_ctrl dut (
      .Clk(Clk), .Reset(Reset), .PushIn(PushIn), .StopIn(StopIn),
      .PushCoef(PushCoef), .CoefAddr(CoefAddr), .CoefWe(CoefWe), .CoefWAddr(CoefWAddr),
      .SampWe(SampWe), .WrPtr(WrPtr), .TapAddr(TapAddr), .RdPtrA(RdPtrA), .RdPtrB(RdPtrB),
      .RdValidA(RdValidA), .RdValidB(RdValidB), .MacEn(MacEn), .MacClr(MacClr),
      .MacPair(MacPair), .PushOut(PushOut), .CoefErr(CoefErr), .StateDbg(StateDbg),
      .FillCnt(FillCnt)
   );

   // ---------------- clock / reset ----------------
   always #5 Clk = ~Clk;
   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] exp_q[$];   // {accept_cycle[21:0], n[4:0], fill[4:0]}

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // ---------------- reference model ----------------
   bit m_loaded, m_err, m_we_nxt, pending_rst, chk_en;
   int m_idle_at, m_wr, m_fill, m_mask, m_waddr_nxt;
   bit e_stop, e_sampwe, e_err, e_we;
   int e_wr, e_fill, e_waddr;
   bit have_cur;
   int tap_exp, cur_acc, cur_n, cur_fill;

   task automatic model_reset();
      m_loaded = 0; m_err = 0; m_we_nxt = 0; m_idle_at = 0;
      m_wr = 0; m_fill = 0; m_mask = 0; m_waddr_nxt = 0;
      exp_q.delete();
      have_cur = 0;
   endtask

   // One clock cycle of stimulus; the model predicts what the DUT shows during this cycle.
   task automatic cycle(input bit rst, input bit pin, input bit pc, input int pa);
      int c, nf;
      bit busy, legal;
      @(posedge Clk);
      #1;
      if (pending_rst) begin
         model_reset();
         chk_en = 1;
      end
      Reset = rst; PushIn = pin; PushCoef = pc; CoefAddr = pa[4:0];
      c = cyc;
      e_wr = m_wr; e_fill = m_fill; e_err = m_err;
      e_we = m_we_nxt; e_waddr = m_waddr_nxt;
      busy = m_loaded && (c < m_idle_at);
      e_stop = !m_loaded || busy;
      e_sampwe = pin && !e_stop;
      legal = pc && pa >= 1 && pa <= 15 && !busy;
      if (pc && !legal) m_err = 1;
      m_we_nxt = legal;
      if (legal) m_waddr_nxt = pa;
      if (!m_loaded) begin
         if (legal) m_mask |= (1 << (pa - 1));
         if (m_mask == 32'h7fff && !pc) begin
            m_loaded = 1;
            m_idle_at = c + 1;
         end
      end
      if (e_sampwe) begin
         nf = (m_fill < 29) ? m_fill + 1 : 29;
         exp_q.push_back({c[21:0], m_wr[4:0], nf[4:0]});
         m_wr = (m_wr + 1) % 32;
         m_fill = nf;
         m_idle_at = c + 18;
      end
      pending_rst = rst;
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [31:0] rec;
      int aa, ab;
      bit pair;
      forever begin
         @(negedge Clk);
         if (chk_en) begin
            check("stop_in", StopIn, e_stop);
            check("samp_we", SampWe, e_sampwe);
            check("wr_ptr", WrPtr, e_wr);
            check("fill_cnt", FillCnt, e_fill);
            check("coef_err", CoefErr, e_err);
            check("coef_we", CoefWe, e_we);
            if (e_we) check("coef_waddr", CoefWAddr, e_waddr);
            if (MacEn) begin
               if (MacClr) begin
                  check("mac_start_expected", 32'(exp_q.size() != 0), 1);
                  if (exp_q.size() != 0) begin
                     rec = exp_q.pop_front();
                     cur_acc = int'(rec[31:10]); cur_n = int'(rec[9:5]); cur_fill = int'(rec[4:0]);
                     have_cur = 1;
                     tap_exp = 1;
                     check("mac_start_cycle", cyc, cur_acc + 1);
                  end
               end else begin
                  tap_exp++;
               end
               check("mac_in_txn", have_cur, 1);
               if (have_cur) begin
                  if (tap_exp == 15) begin aa = 14; ab = 14; pair = 0; end
                  else begin aa = tap_exp - 1; ab = 29 - tap_exp; pair = 1; end
                  check("tap_addr", TapAddr, tap_exp);
                  check("rd_ptr_a", RdPtrA, (cur_n - aa + 32) % 32);
                  check("rd_ptr_b", RdPtrB, (cur_n - ab + 32) % 32);
                  check("rd_valid_a", RdValidA, aa < cur_fill);
                  check("rd_valid_b", RdValidB, ab < cur_fill);
                  check("mac_pair", MacPair, pair);
               end
            end
            if (PushOut) begin
               check("push_out_expected", have_cur, 1);
               if (have_cur) begin
                  check("push_out_latency", cyc, cur_acc + 17);
                  check("taps_seen", tap_exp, 15);
                  have_cur = 0;
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic load_coefs(input bit descending);
      for (int a = 1; a <= 15; a++) cycle(0, 0, 1, descending ? 16 - a : a);
      cycle(0, 0, 0, 0);
   endtask

   task automatic idle_cycles(input int k);
      for (int i = 0; i < k; i++) cycle(0, 0, 0, 0);
   endtask

   initial begin
      repeat (3) cycle(1, 0, 0, 0);
      @(negedge Clk);
      check("rst_state", 32'(StateDbg), 32'(LOAD));
      check("rst_tap_addr", TapAddr, 0);
      check("rst_rd_ptr_a", RdPtrA, 0);
      check("rst_rd_ptr_b", RdPtrB, 0);
      check("rst_mac_en", MacEn, 0);
      check("rst_push_out", PushOut, 0);
      check("rst_coef_waddr", CoefWAddr, 0);

      load_coefs(0);
      cycle(0, 0, 0, 0);
      @(negedge Clk);
      check("load_done_state", 32'(StateDbg), 32'(IDLE));

      cycle(0, 1, 0, 0);          // first sample at WrPtr=0
      idle_cycles(20);

      repeat (40 * 18) cycle(0, 1, 0, 0);   // continuous push, pointer wraps
      idle_cycles(20);

      cycle(0, 0, 1, 0);          // illegal addresses while IDLE
      cycle(0, 0, 1, 20);
      cycle(0, 1, 0, 0);
      idle_cycles(3);
      cycle(0, 0, 1, 5);          // legal address but block is in MAC
      idle_cycles(20);
      cycle(0, 1, 1, 7);          // sample and coefficient in the same IDLE cycle
      idle_cycles(20);

      repeat (800) begin
         cycle(0, $urandom_range(0, 99) < 60, $urandom_range(0, 9) == 0, $urandom_range(0, 31));
      end
      idle_cycles(20);

      cycle(0, 1, 0, 0);          // reset aborts at tap 7
      idle_cycles(6);
      cycle(1, 0, 0, 0);
      cycle(0, 0, 0, 0);
      @(negedge Clk);
      check("abort_state", 32'(StateDbg), 32'(LOAD));
      check("abort_stop_in", StopIn, 1);
      check("abort_fill_cnt", FillCnt, 0);
      idle_cycles(20);

      load_coefs(1);
      cycle(0, 1, 0, 0);
      idle_cycles(20);

      check("sb_drained", exp_q.size() + int'(have_cur), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
